hex_scan_ctrl: RTL
==================

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SCAN_DIV, 50000, clk cycles between digit-refresh ticks (min 3).
REQ-002 BLINK_DIV, 12500000, clk cycles per blink phase (min 2).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  single-digit write strobe, one cycle.
REQ-006 wr_addr  input  3  digit index 0..5; values 6,7 ignored.
REQ-007 wr_data  input  4  hex nibble for addressed digit.
REQ-008 wr_blank  input  1  blank flag for addressed digit.
REQ-009 wr_blink  input  1  blink flag for addressed digit.
REQ-010 load  input  1  bulk-load request, held until accepted.
REQ-011 load_value  input  24  six nibbles, digit i = bits [4i+3:4i].
REQ-012 load_ready  output  1  bulk load accepted in any cycle where load and load_ready are both high.
REQ-013 hex  output  42  active-low segments, digit i = bits [7i+6:7i], bit order 0..6 = segments a..g.

Function
REQ-014 Per digit, the block SHALL hold a 4-bit nibble, a blank flag and a blink flag.
REQ-015 A free-running tick counter SHALL count 0..SCAN_DIV-1 and pulse tick on wrap.
REQ-016 The FSM SHALL have states IDLE, DECODE and LATCH: IDLE->DECODE on tick; DECODE->LATCH unconditionally; LATCH->IDLE unconditionally.
REQ-017 In DECODE, the block SHALL register nibble[idx] into the single shared decoder input.
REQ-018 In LATCH, hex[idx] SHALL receive 7'h7F if blank[idx] is set, or if blink[idx] is set and blink_phase=0; otherwise it SHALL receive the decoder output.
REQ-019 In LATCH, idx SHALL advance 0..5 and wrap 5->0; other digits SHALL hold their value.
REQ-020 The digit shown SHALL be the one refreshed with the state sampled in DECODE; worst-case write-to-visible latency is 6*SCAN_DIV+2 cycles.
REQ-021 The decoder SHALL map 0-9,A-F to standard active-low glyphs (0 = 7'h40, 8 = 7'h00, F = 7'h0E).
REQ-022 load_ready SHALL be 1 exactly when state=IDLE.
REQ-023 An accepted load SHALL write all six nibbles and clear all blank and blink flags in the same cycle.
REQ-024 wr_en SHALL be accepted in every state; a write to a valid wr_addr updates that digit's nibble, blank and blink flags next cycle.
REQ-025 On simultaneous wr_en and accepted load, the load SHALL win and the write SHALL be dropped.
REQ-026 On wr_en with load not accepted, the write SHALL apply.
REQ-027 A write to the digit currently in DECODE/LATCH SHALL not corrupt that refresh; the new value appears on that digit's next refresh.
REQ-028 A blink counter SHALL toggle blink_phase every BLINK_DIV cycles, independent of the FSM.

Reset
REQ-029 Asserting reset SHALL immediately set: hex = all 7'h7F; nibbles = 0; blank flags = 0; blink flags = 0; idx = 0; FSM = IDLE; both counters = 0; blink_phase = 1; decoder input register = 0.
REQ-030 load_ready SHALL be 1 during reset, as a consequence of IDLE.
REQ-031 Reset mid-refresh SHALL abandon the refresh; the first tick after release refreshes digit 0.

Structure
REQ-032 The shared header hex_ctrl_defs SHALL hold: state encodings (IDLE = 0, DECODE = 1, LATCH = 2), NUM_DIGITS = 6 and BLANK_SEG = 7'h7F.
REQ-033 The block SHALL instantiate exactly one seg7 decoder sub-module (in[3:0] -> display[6:0]) shared by all six digits.

Verification (SCAN_DIV=4, BLINK_DIV=8)
REQ-034 Reset released, no writes -> all hex = 7'h7F until each digit's refresh, then 7'h40; load_ready = 1 in IDLE.
REQ-035 load_value = 24'hFEDCBA, accepted -> after 24+2 cycles, hex digits 5..0 = F,E,D,C,B,A glyphs; load_ready low in DECODE/LATCH.
REQ-036 wr_en with wr_addr = 3, wr_data = 8, wr_blink = 1 -> digit 3 alternates 7'h00 / 7'h7F on refreshes tracking blink_phase.
REQ-037 Same-cycle wr_en (addr 0, data 1) and accepted load 24'h000000 -> digit 0 shows 7'h40, not 7'h79.
REQ-038 wr_addr = 6 -> no digit changes; wr_blank on digit 2 -> that digit is 7'h7F after its refresh.
REQ-039 Reset asserted in LATCH of digit 4 -> hex = all 7'h7F immediately; after release, digit 0 is refreshed first.

Source files
------------

// File: rtl/hex_ctrl_defs.sv
// ----------------------------------------------------------------------------
// hex_ctrl_defs
// Shared definitions for the six-digit hex display scan controller:
//   - state_e    : refresh FSM encodings (IDLE = 0, DECODE = 1, LATCH = 2)
//   - NUM_DIGITS : number of seven-segment digits driven
//   - BLANK_SEG  : active-low pattern with every segment off
//   - next_idx() : digit index successor with wrap to 0
// ----------------------------------------------------------------------------
package hex_ctrl_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        LATCH  = 2'd2
    } state_e;

    localparam int unsigned NUM_DIGITS = 6;
    localparam logic [6:0]  BLANK_SEG  = 7'h7F;

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_seg7.sv
// ----------------------------------------------------------------------------
// hex_scan_ctrl_seg7
// Combinational hex-nibble to seven-segment decoder, active-low outputs.
// Bit order of o_display: bit 0 = segment a ... bit 6 = segment g.
// Ports:
//   i_in      [3:0]  nibble to display (0-9, A-F)
//   o_display [6:0]  active-low segment pattern
// ----------------------------------------------------------------------------
module hex_scan_ctrl_seg7
    import hex_ctrl_defs::*;
(
    input  logic [3:0] i_in,
    output logic [6:0] o_display
);

    always_comb begin
        o_display = BLANK_SEG;
        case (i_in)
            4'h0: o_display = 7'h40;
            4'h1: o_display = 7'h79;
            4'h2: o_display = 7'h24;
            4'h3: o_display = 7'h30;
            4'h4: o_display = 7'h19;
            4'h5: o_display = 7'h12;
            4'h6: o_display = 7'h02;
            4'h7: o_display = 7'h78;
            4'h8: o_display = 7'h00;
            4'h9: o_display = 7'h10;
            4'hA: o_display = 7'h08;
            4'hB: o_display = 7'h03;
            4'hC: o_display = 7'h46;
            4'hD: o_display = 7'h21;
            4'hE: o_display = 7'h06;
            4'hF: o_display = 7'h0E;
            default: o_display = BLANK_SEG;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// ----------------------------------------------------------------------------
// hex_scan_ctrl
// Six-digit seven-segment scan controller. Each digit holds a nibble plus
// blank and blink flags. A free-running tick walks a three-state FSM
// (IDLE -> DECODE -> LATCH) that refreshes one digit per tick through a single
// shared decoder. A separate blink counter toggles the blink phase.
// Parameters:
//   SCAN_DIV  clk cycles between digit-refresh ticks (>= 3)
//   BLINK_DIV clk cycles per blink phase (>= 2)
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_wr_en             single-digit write strobe
//   i_wr_addr  [2:0]    digit index 0..5 (6, 7 ignored)
//   i_wr_data  [3:0]    nibble for the addressed digit
//   i_wr_blank          blank flag for the addressed digit
//   i_wr_blink          blink flag for the addressed digit
//   i_load              bulk-load request, held until accepted
//   i_load_value [23:0] six nibbles, digit i = bits [4i+3:4i]
//   o_load_ready        high in IDLE; load accepted when i_load & o_load_ready
//   o_hex [41:0]        active-low segments, digit i = bits [7i+6:7i]
// ----------------------------------------------------------------------------
module hex_scan_ctrl
    import hex_ctrl_defs::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_addr,
    input  logic [3:0]  i_wr_data,
    input  logic        i_wr_blank,
    input  logic        i_wr_blink,
    input  logic        i_load,
    input  logic [23:0] i_load_value,
    output logic        o_load_ready,
    output logic [41:0] o_hex
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e                  r_state;
    state_e                  w_state_next;
    logic [SCAN_W-1:0]       r_scan_cnt;
    logic [BLINK_W-1:0]      r_blink_cnt;
    logic                    r_blink_phase;
    logic [2:0]              r_idx;
    logic [3:0]              r_nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_blink;
    logic [3:0]              r_dec_in;
    logic                    r_dec_blank;
    logic                    r_dec_blink;
    logic [41:0]             r_hex;

    logic                    w_tick;
    logic                    w_decode_en;
    logic                    w_latch_en;
    logic                    w_load_acc;
    logic                    w_wr_valid;
    logic [6:0]              w_seg_out;
    logic [6:0]              w_latch_seg;

    // ------------------------------------------------------------------
    // Refresh tick: counts 0..SCAN_DIV-1, pulses on the last count
    // ------------------------------------------------------------------
    assign w_tick = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scan_cnt <= '0;
        end else if (w_tick) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Blink phase: free-running, independent of the refresh FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_tick) w_state_next = DECODE;
            DECODE:  w_state_next = LATCH;
            LATCH:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_load_ready = 1'b0;
        w_decode_en  = 1'b0;
        w_latch_en   = 1'b0;
        case (r_state)
            IDLE:    o_load_ready = 1'b1;
            DECODE:  w_decode_en  = 1'b1;
            LATCH:   w_latch_en   = 1'b1;
            default: o_load_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit storage: an accepted bulk load beats a same-cycle write
    // ------------------------------------------------------------------
    assign w_load_acc = i_load && o_load_ready;
    assign w_wr_valid = i_wr_en && (i_wr_addr < 3'(NUM_DIGITS));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_nibble[i] <= 4'h0;
            end
            r_blank <= '0;
            r_blink <= '0;
        end else if (w_load_acc) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_nibble[i] <= i_load_value[4*i +: 4];
            end
            r_blank <= '0;
            r_blink <= '0;
        end else if (w_wr_valid) begin
            r_nibble[i_wr_addr] <= i_wr_data;
            r_blank[i_wr_addr]  <= i_wr_blank;
            r_blink[i_wr_addr]  <= i_wr_blink;
        end
    end

    // ------------------------------------------------------------------
    // Decode stage: snapshot the digit's nibble and flags so a write
    // landing during DECODE/LATCH only shows on the next refresh.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dec_in    <= 4'h0;
            r_dec_blank <= 1'b0;
            r_dec_blink <= 1'b0;
        end else if (w_decode_en) begin
            r_dec_in    <= r_nibble[r_idx];
            r_dec_blank <= r_blank[r_idx];
            r_dec_blink <= r_blink[r_idx];
        end
    end

    hex_scan_ctrl_seg7 u_seg7 (
        .i_in      (r_dec_in),
        .o_display (w_seg_out)
    );

    // Blinking digits go dark while the blink phase is low
    assign w_latch_seg = (r_dec_blank || (r_dec_blink && !r_blink_phase)) ? BLANK_SEG
                                                                          : w_seg_out;

    // ------------------------------------------------------------------
    // Latch stage: update only the current digit, then advance the index
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hex <= {NUM_DIGITS{BLANK_SEG}};
            r_idx <= 3'd0;
        end else if (w_latch_en) begin
            r_hex[7*r_idx +: 7] <= w_latch_seg;
            r_idx               <= next_idx(r_idx);
        end
    end

    assign o_hex = r_hex;

endmodule
